// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state encoding, frame opcodes and ALU function-code
// fields for the ALU command controller.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_A   = 3'd1,
    WAIT_B   = 3'd2,
    WAIT_FUN = 3'd3,
    ALU_EXEC = 3'd4,
    TX_LSB   = 3'd5,
    TX_MSB   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_ALU_WOP = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int ALU_FUN_W = 4;

  localparam logic [1:0] UNIT_ARITH = 2'h0;
  localparam logic [1:0] UNIT_LOGIC = 2'h1;
  localparam logic [1:0] UNIT_CMP   = 2'h2;
  localparam logic [1:0] UNIT_SHIFT = 2'h3;

  function automatic logic [1:0] fun_unit(input logic [ALU_FUN_W-1:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_exec_watchdog.sv
// alu_exec_watchdog: counts cycles spent waiting on the ALU and flags
// expiry on the TIMEOUT-th cycle; clears whenever the wait ends.
module alu_exec_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses 0xCC/0xDD command frames, loads operands, runs the ALU
// and returns the 16-bit result LSB first. ALU_TIMEOUT_EN adds an exec watchdog.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [15:0]          ALU_OUT,
  input  logic                 ALU_OUT_VALID,
  input  logic                 FIFO_FULL,
  output logic                 ALU_EN,
  output logic [ALU_FUN_W-1:0] ALU_FUN,
  output logic                 CLK_GATE_EN,
  output logic                 RF_WR_EN,
  output logic [ADDR_W-1:0]    RF_ADDR,
  output logic [DATA_W-1:0]    RF_WR_DATA,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  output logic                 BUSY
);

  state_t                 state, state_nx;
  logic [15:0]            result, result_nx;
  logic                   alu_en_nx, gate_nx, rf_wr_en_nx, tx_vld_nx, busy_nx;
  logic [ALU_FUN_W-1:0]   fun_nx;
  logic [ADDR_W-1:0]      rf_addr_nx;
  logic [DATA_W-1:0]      rf_data_nx, tx_data_nx;
  logic                   timeout_hit;

`ifdef ALU_TIMEOUT_EN
  alu_exec_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (CLK),
    .rst_n   (RST),
    .en      (state == ALU_EXEC),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    result_nx   = result;
    alu_en_nx   = ALU_EN;
    gate_nx     = CLK_GATE_EN;
    fun_nx      = ALU_FUN;
    rf_wr_en_nx = 1'b0;
    rf_addr_nx  = RF_ADDR;
    rf_data_nx  = RF_WR_DATA;
    tx_vld_nx   = 1'b0;
    tx_data_nx  = TX_P_DATA;

    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_W'(CMD_ALU_WOP))      state_nx = WAIT_A;
          else if (RX_P_DATA == DATA_W'(CMD_ALU_NOP)) state_nx = WAIT_FUN;
        end
      end
      WAIT_A: begin
        if (RX_D_VLD) begin
          rf_wr_en_nx = 1'b1;
          rf_addr_nx  = ADDR_W'(OPA_ADDR);
          rf_data_nx  = RX_P_DATA;
          state_nx    = WAIT_B;
        end
      end
      WAIT_B: begin
        if (RX_D_VLD) begin
          rf_wr_en_nx = 1'b1;
          rf_addr_nx  = ADDR_W'(OPB_ADDR);
          rf_data_nx  = RX_P_DATA;
          state_nx    = WAIT_FUN;
        end
      end
      WAIT_FUN: begin
        if (RX_D_VLD) begin
          fun_nx    = RX_P_DATA[ALU_FUN_W-1:0];
          alu_en_nx = 1'b1;
          gate_nx   = 1'b1;
          state_nx  = ALU_EXEC;
        end
      end
      ALU_EXEC: begin
        // A real result always wins over a watchdog expiry in the same cycle.
        if (ALU_OUT_VALID) begin
          result_nx = ALU_OUT;
          alu_en_nx = 1'b0;
          gate_nx   = 1'b0;
          state_nx  = TX_LSB;
        end else if (timeout_hit) begin
          result_nx = 16'hFFFF;
          alu_en_nx = 1'b0;
          gate_nx   = 1'b0;
          state_nx  = TX_LSB;
        end
      end
      TX_LSB: begin
        if (!FIFO_FULL) begin
          tx_vld_nx  = 1'b1;
          tx_data_nx = DATA_W'(result[7:0]);
          state_nx   = TX_MSB;
        end
      end
      TX_MSB: begin
        if (!FIFO_FULL) begin
          tx_vld_nx  = 1'b1;
          tx_data_nx = DATA_W'(result[15:8]);
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      result      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      RF_WR_EN    <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_nx;
      result      <= result_nx;
      ALU_EN      <= alu_en_nx;
      ALU_FUN     <= fun_nx;
      CLK_GATE_EN <= gate_nx;
      RF_WR_EN    <= rf_wr_en_nx;
      RF_ADDR     <= rf_addr_nx;
      RF_WR_DATA  <= rf_data_nx;
      TX_P_DATA   <= tx_data_nx;
      TX_D_VLD    <= tx_vld_nx;
      BUSY        <= busy_nx;
    end
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command-side controller for the ALU.
- Parses byte frames from the UART RX path and writes operands into the register file.
- Drives ALU_EN/ALU_FUN into the ALU function decoder and waits for the ALU's OUT_VALID.
- Returns the 16-bit result to the TX FIFO as two bytes, LSB first.
- Sits in the REF_CLK domain between the RX data synchronizer, register file, ALU and TX FIFO.

Parameters:
- DATA_W, 8, byte width of RX/TX/register-file data.
- ADDR_W, 4, register-file address width.
- OPA_ADDR, 0, register-file address for operand A.
- OPB_ADDR, 1, register-file address for operand B.
- TIMEOUT, 15, max cycles in ALU_EXEC before abort; used only with ALU_TIMEOUT_EN.

Ports:
- CLK  in  1  system (REF) clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_W  received byte.
- RX_D_VLD  in  1  single-cycle strobe qualifying RX_P_DATA.
- ALU_OUT  in  16  ALU result.
- ALU_OUT_VALID  in  1  ALU result valid.
- FIFO_FULL  in  1  TX FIFO full; backpressure.
- ALU_EN  out  1  ALU enable.
- ALU_FUN  out  4  ALU function code; [3:2] selects the unit, [1:0] the operation.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- RF_WR_EN  out  1  register-file write strobe.
- RF_ADDR  out  ADDR_W  register-file address.
- RF_WR_DATA  out  DATA_W  register-file write data.
- TX_P_DATA  out  DATA_W  byte to TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- All outputs are registered and reset to 0. FSM resets to IDLE; result register resets to 0.
- Frames:
  - 0xCC, opA, opB, fun: write operands, then execute.
  - 0xDD, fun: execute on the stored operands.
  - fun uses bits [3:0]; bits [7:4] are ignored.
- States: IDLE, WAIT_A, WAIT_B, WAIT_FUN, ALU_EXEC, TX_LSB, TX_MSB.
- IDLE:
  - RX byte 0xCC -> WAIT_A.
  - RX byte 0xDD -> WAIT_FUN.
  - Any other byte is dropped; stay in IDLE.
- WAIT_A: on RX_D_VLD, next cycle RF_WR_EN=1 for exactly one cycle with RF_ADDR=OPA_ADDR, RF_WR_DATA=byte -> WAIT_B.
- WAIT_B: same with OPB_ADDR -> WAIT_FUN.
- WAIT_FUN: on RX_D_VLD, latch fun into ALU_FUN -> ALU_EXEC.
- ALU_EXEC:
  - ALU_EN and CLK_GATE_EN go high the cycle after the fun byte is accepted.
  - ALU_FUN is held stable throughout ALU_EXEC.
  - On the first cycle ALU_OUT_VALID is sampled high: capture ALU_OUT, deassert ALU_EN/CLK_GATE_EN next cycle -> TX_LSB.
  - ALU_OUT_VALID outside ALU_EXEC is ignored.
- TX_LSB: when FIFO_FULL=0, pulse TX_D_VLD one cycle with result[7:0] -> TX_MSB. While FIFO_FULL=1, hold with no strobe.
- TX_MSB: same with result[15:8] -> IDLE.
- RX bytes arriving in ALU_EXEC/TX_LSB/TX_MSB are dropped. Frames are not queued.
- Latency, fun byte accepted at edge N with a 1-cycle ALU and FIFO not full:
  - ALU_EN high from N+1.
  - Result captured at N+2.
  - LSB strobe at N+3, MSB strobe at N+4.
- Back-to-back: a new 0xCC accepted in the cycle IDLE is re-entered is honoured.
- Reset mid-operation: immediate return to IDLE, all strobes low, partial frame discarded. Register-file contents are not touched.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - A counter runs in ALU_EXEC.
  - If ALU_OUT_VALID is not seen within TIMEOUT cycles, result is forced to 16'hFFFF, ALU_EN drops and the FSM goes to TX_LSB, transmitting 0xFF, 0xFF.
  - The counter clears on leaving ALU_EXEC.
- Undefined: no counter; ALU_EXEC waits indefinitely for ALU_OUT_VALID.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum;
  - opcode constants CMD_ALU_WOP=8'hCC and CMD_ALU_NOP=8'hDD;
  - ALU_FUN width;
  - unit-select codes: arith 2'h0, logic 2'h1, compare 2'h2, shift 2'h3.
- No sub-module for the base block. Under ALU_TIMEOUT_EN the counter is the natural sub-module, alu_exec_watchdog.

Test Plan:
- Frame 0xCC,0x05,0x03,0x00 with model ALU_OUT=0x0008 -> RF writes addr0=0x05 then addr1=0x03, one pulse each; ALU_FUN=4'h0; TX bytes 0x08 then 0x00; BUSY returns low.
- Frame 0xDD,0x01 with model ALU_OUT=0x0102 -> no RF_WR_EN; ALU_FUN=4'h1; TX bytes 0x02 then 0x01.
- FIFO_FULL held high for 5 cycles in TX_LSB -> no TX_D_VLD during the stall; 0x08 sent on the first non-full cycle; no duplicate strobe.
- Byte 0x55 in IDLE, and 0xCC sent during ALU_EXEC -> both ignored; no state change; result frame unaffected.
- RST low after 0xCC,0x05 -> all outputs 0; FSM in IDLE; a following 0xDD,0x2 frame executes with ALU_FUN=4'h2.
- With ALU_TIMEOUT_EN and ALU_OUT_VALID held low -> ALU_EN drops after 15 cycles; TX bytes 0xFF, 0xFF.
